// File: rtl/surf_trig_rx.sv
// Receive side of the SURF trigger stream: validates trigger words, checks spacing,
// tracks run state and presents decoded triggers. Optional macro: TRIG_RX_TIMESTAMP_EN.
module surf_trig_rx #(
  parameter int    MIN_SPACING  = 8,
  parameter int    COUNT_WIDTH  = 16,
  parameter string CHECK_FORMAT = "TRUE"
) (
  input  logic                   ifclk,
  input  logic                   rst_i,
  input  logic                   runrst_i,
  input  logic                   runstop_i,
  input  logic                   err_clr_i,
  input  logic [31:0]            s_trig_tdata,
  input  logic                   s_trig_tvalid,
  output logic                   s_trig_tready,
  output logic                   trig_valid_o,
  input  logic                   trig_ready_i,
  output logic [11:0]            trig_addr_o,
  output logic [7:0]             trig_meta_o,
`ifdef TRIG_RX_TIMESTAMP_EN
  output logic [31:0]            trig_time_o,
`endif
  output logic                   running_o,
  output logic                   err_format_o,
  output logic                   err_spacing_o,
  output logic [COUNT_WIDTH-1:0] trig_count_o,
  output logic [COUNT_WIDTH-1:0] fmt_err_count_o,
  output logic [COUNT_WIDTH-1:0] stale_count_o
);

  localparam logic [11:0] MIN_SP = 12'(MIN_SPACING);
  localparam bit          CHK_EN = (CHECK_FORMAT == "TRUE");

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} run_state_t;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic fmt_ok(input logic [31:0] w);
    return (w[31:30] == 2'b10) && (w[17:16] == 2'b00) && (w[15:8] == 8'h00);
  endfunction

  run_state_t  state_r;
  logic        first_flag_r;
  logic [11:0] last_addr_r;
`ifdef TRIG_RX_TIMESTAMP_EN
  logic [31:0] ts_r;
`endif

  logic        accept_s;
  logic        good_s;
  logic        bad_s;
  logic        stale_s;
  logic        spacing_bad_s;
  logic [11:0] addr_s;
  logic [11:0] delta_s;

  assign s_trig_tready = !trig_valid_o || trig_ready_i;

  // Classify the word accepted this cycle and compute its address delta.
  always_comb begin
    accept_s      = s_trig_tvalid && s_trig_tready;
    addr_s        = s_trig_tdata[29:18];
    delta_s       = addr_s - last_addr_r;
    stale_s       = accept_s && (state_r == ST_STOPPED);
    good_s        = accept_s && (state_r == ST_RUNNING) && (!CHK_EN || fmt_ok(s_trig_tdata));
    bad_s         = accept_s && (state_r == ST_RUNNING) && !good_s;
    spacing_bad_s = good_s && !first_flag_r && (delta_s < MIN_SP);
  end

  // Run state, output register, spacing history, sticky flags and counters.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      state_r         <= ST_STOPPED;
      running_o       <= 1'b0;
      first_flag_r    <= 1'b1;
      last_addr_r     <= 12'h000;
      trig_valid_o    <= 1'b0;
      trig_addr_o     <= 12'h000;
      trig_meta_o     <= 8'h00;
      err_format_o    <= 1'b0;
      err_spacing_o   <= 1'b0;
      trig_count_o    <= '0;
      fmt_err_count_o <= '0;
      stale_count_o   <= '0;
`ifdef TRIG_RX_TIMESTAMP_EN
      ts_r            <= 32'h0000_0000;
      trig_time_o     <= 32'h0000_0000;
`endif
    end else begin
      if (runrst_i) begin
        state_r   <= ST_RUNNING;
        running_o <= 1'b1;
      end else if (runstop_i) begin
        state_r   <= ST_STOPPED;
        running_o <= 1'b0;
      end

      if (good_s) begin
        trig_valid_o <= 1'b1;
        trig_addr_o  <= addr_s;
        trig_meta_o  <= s_trig_tdata[7:0];
`ifdef TRIG_RX_TIMESTAMP_EN
        trig_time_o  <= ts_r;
`endif
        last_addr_r  <= addr_s;
        first_flag_r <= 1'b0;
      end else if (trig_ready_i) begin
        trig_valid_o <= 1'b0;
      end

      // A run start re-arms the first-trigger exemption even if a word lands the same cycle.
      if (runrst_i) begin
        first_flag_r <= 1'b1;
      end

      if (err_clr_i) begin
        err_format_o    <= 1'b0;
        err_spacing_o   <= 1'b0;
        trig_count_o    <= '0;
        fmt_err_count_o <= '0;
        stale_count_o   <= '0;
      end else begin
        if (bad_s)         err_format_o    <= 1'b1;
        if (spacing_bad_s) err_spacing_o   <= 1'b1;
        if (good_s)        trig_count_o    <= sat_inc(trig_count_o);
        if (bad_s)         fmt_err_count_o <= sat_inc(fmt_err_count_o);
        if (stale_s)       stale_count_o   <= sat_inc(stale_count_o);
      end

`ifdef TRIG_RX_TIMESTAMP_EN
      if (runrst_i) begin
        ts_r <= 32'h0000_0000;
      end else if (state_r == ST_RUNNING) begin
        ts_r <= ts_r + 32'h0000_0001;
      end
`endif
    end
  end

endmodule
